// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
// Parallel request/response bundle between a requester and serial_add_ctrl.
//   start   : request, sampled by the sequencer only while idle
//   a, b    : operands, captured when start is accepted
//   cin     : carry-in, captured when start is accepted
//   busy    : sequencer is shifting or signalling completion
//   done    : one-cycle completion pulse
//   sum     : parallel result, held until the next completion
//   cout    : final carry-out, held with sum
//   bit_idx : index of the bit currently being added (0 when not shifting)
// master = requester side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
   parameter int WIDTH = 4
);
   localparam int CNT_W = $clog2(WIDTH);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic [CNT_W-1:0] bit_idx;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, bit_idx
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, bit_idx
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Sequencer for a bit-serial adder. Operands accepted on the parallel bus are
// shifted LSB-first into an external combinational full adder, one bit per
// clock. The running carry is held in carry_q, the serial sum bits are
// reassembled into a parallel result, and completion is flagged with a
// one-cycle done pulse.
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : parallel request/response bundle (slave side)
//   fa_a     : serial bit of A to the full adder
//   fa_b     : serial bit of B to the full adder
//   fa_cin   : registered carry to the full adder
//   fa_sum   : full-adder sum bit
//   fa_carry : full-adder carry bit
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   serial_add_ctrl_if.slave  bus,
   output logic              fa_a,
   output logic              fa_b,
   output logic              fa_cin,
   input  logic              fa_sum,
   input  logic              fa_carry
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             carry_q;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   // The bit entering the result on this edge; also the MSB of the final sum.
   logic [WIDTH-1:0] res_next;
   assign res_next = {fa_sum, res_sh[WIDTH-1:1]};

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and Moore outputs; the full adder is only driven in SHIFT
   always_comb begin
      state_d     = state_q;
      bus.busy    = 1'b0;
      bus.done    = 1'b0;
      bus.bit_idx = '0;
      fa_a        = 1'b0;
      fa_b        = 1'b0;
      fa_cin      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            bus.busy    = 1'b1;
            bus.bit_idx = cnt;
            fa_a        = a_sh[0];
            fa_b        = b_sh[0];
            fa_cin      = carry_q;
            if (cnt == LAST_BIT) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Operand capture, serial shifting and result assembly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  a_sh    <= bus.a;
                  b_sh    <= bus.b;
                  carry_q <= bus.cin;
                  cnt     <= '0;
               end
            end
            S_SHIFT: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               res_sh  <= res_next;
               carry_q <= fa_carry;
               cnt     <= cnt + CNT_W'(1);
               // Publish on the last bit so sum/cout change only at completion.
               if (cnt == LAST_BIT) begin
                  sum_q  <= res_next;
                  cout_q <= fa_carry;
               end
            end
            default: begin
            end
         endcase
      end
   end
endmodule
